// File: rtl/data_memory_pipe.sv
// Pipelined byte-addressable data memory with configurable read latency.
// Define DMEM_MISALIGN_TRAP_EN to report misaligned half/word accesses as errors.
module data_memory_pipe #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic        valid;
        logic        err;
        logic [31:0] data;
    } resp_t;

    logic [31:0]   mem [DEPTH];
    logic          ready_q;
    logic          accept;
    logic [AW-1:0] idx;
    logic [1:0]    off;
    logic          err_in;
    logic [3:0]    be;
    logic [31:0]   wdata_rep;
    logic          unused_addr;

    logic [31:0]   raw_q;
    logic          s0_valid;
    logic          s0_we;
    logic          s0_err;
    logic          s0_uns;
    logic [1:0]    s0_size;
    logic [1:0]    s0_off;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    resp_t         head;
    resp_t         tail;

    assign req_ready_o = ready_q;
    assign accept      = req_valid_i & ready_q;
    assign idx         = req_addr_i[AW+1:2];
    assign unused_addr = ^req_addr_i[31:AW+2];

    always_comb begin
        off    = req_addr_i[1:0];
        err_in = (req_size_i == 2'b11);
`ifdef DMEM_MISALIGN_TRAP_EN
        if (req_size_i == 2'b01 && req_addr_i[0])
            err_in = 1'b1;
        if (req_size_i == 2'b10 && req_addr_i[1:0] != 2'b00)
            err_in = 1'b1;
`else
        if (req_size_i == 2'b01)
            off[0] = 1'b0;
        if (req_size_i == 2'b10)
            off = 2'b00;
`endif
    end

    always_comb begin
        be        = 4'b0000;
        wdata_rep = req_wdata_i;
        unique case (req_size_i)
            2'b00: begin
                be        = 4'b0001 << off;
                wdata_rep = {4{req_wdata_i[7:0]}};
            end
            2'b01: begin
                be        = off[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{req_wdata_i[15:0]}};
            end
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    // Array is never reset; the read samples the word before any same-edge write.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            raw_q <= mem[idx];
            if (req_we_i && !err_in) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b])
                        mem[idx][8*b +: 8] <= wdata_rep[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ready_q  <= 1'b0;
            s0_valid <= 1'b0;
            s0_we    <= 1'b0;
            s0_err   <= 1'b0;
            s0_uns   <= 1'b0;
            s0_size  <= 2'b00;
            s0_off   <= 2'b00;
        end else begin
            ready_q  <= 1'b1;
            s0_valid <= accept;
            if (accept) begin
                s0_we   <= req_we_i;
                s0_err  <= err_in;
                s0_uns  <= req_unsigned_i;
                s0_size <= req_size_i;
                s0_off  <= off;
            end
        end
    end

    assign byte_sel = raw_q[{s0_off, 3'b000} +: 8];
    assign half_sel = raw_q[{s0_off[1], 4'b0000} +: 16];

    always_comb begin
        head       = '0;
        head.valid = s0_valid;
        head.err   = s0_valid & s0_err;
        if (s0_valid && !s0_err && !s0_we) begin
            unique case (s0_size)
                2'b00: head.data = s0_uns ? {24'b0, byte_sel}
                                          : {{24{byte_sel[7]}}, byte_sel};
                2'b01: head.data = s0_uns ? {16'b0, half_sel}
                                          : {{16{half_sel[15]}}, half_sel};
                2'b10:   head.data = raw_q;
                default: head.data = '0;
            endcase
        end
    end

    generate
        if (LATENCY == 1) begin : g_direct
            assign tail = head;
        end else begin : g_pipe
            resp_t q [LATENCY-1];
            always_ff @(posedge clk_i or negedge rst_i) begin
                if (!rst_i) begin
                    for (int i = 0; i < LATENCY - 1; i++)
                        q[i] <= '0;
                end else begin
                    q[0] <= head;
                    for (int i = 1; i < LATENCY - 1; i++)
                        q[i] <= q[i-1];
                end
            end
            assign tail = q[LATENCY-2];
        end
    endgenerate

    assign resp_valid_o = tail.valid;
    assign resp_rdata_o = tail.valid ? tail.data : 32'h0;
    assign resp_err_o   = tail.valid & tail.err;

endmodule

// File: doc/data_memory_pipe.md
DATA_MEMORY_PIPE -- requirements
Module: data_memory_pipe

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, meaning the number of 32-bit words; it is a power of two, 16 to 65536.
REQ-002 SHALL have parameter LATENCY, default 1, meaning the number of cycles from request acceptance to response; legal range 1 to 4.
REQ-003 SHALL have port clk_i  input  1  clock; all logic is on the rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid_i  input  1  request present.
REQ-006 SHALL have port req_ready_o  output  1  request accepted this cycle if also valid.
REQ-007 SHALL have port req_we_i  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr_i  input  32  byte address.
REQ-009 SHALL have port req_size_i  input  2  access size: 00 byte, 01 half, 10 word; 11 is illegal.
REQ-010 SHALL have port req_unsigned_i  input  1  load zero-extends when 1 and sign-extends when 0.
REQ-011 SHALL have port req_wdata_i  input  32  store data, right-aligned (LSB-justified).
REQ-012 SHALL have port resp_valid_o  output  1  response present, one-cycle pulse per accepted request.
REQ-013 SHALL have port resp_rdata_o  output  32  load result; 0 for stores and errors.
REQ-014 SHALL have port resp_err_o  output  1  access error; qualified by resp_valid_o.

Function
REQ-015 SHALL accept a request on a rising edge where req_valid_i=1 and req_ready_o=1.
REQ-016 SHALL drive req_ready_o=1 in every cycle except while rst_i=0 and the first cycle after rst_i deasserts.
REQ-017 SHALL index words by req_addr_i[log2(DEPTH)+1:2]; higher address bits are ignored, so addresses wrap modulo 4*DEPTH.
REQ-018 SHALL be fully pipelined: one accepted request per cycle, with responses in acceptance order.
REQ-019 SHALL assert resp_valid_o exactly LATENCY cycles after the acceptance edge.
REQ-020 SHALL commit a store to the array on its acceptance edge, writing only the addressed byte lanes.
REQ-021 SHALL write byte lane addr[1:0] for a byte store, lanes addr[1]*2 and addr[1]*2+1 for a half store, and all 4 lanes for a word store; write data is replicated to the target lanes from wdata[7:0] or wdata[15:0].
REQ-022 SHALL sample the array for a load on its acceptance edge, then extract, shift and extend the result per size and unsigned.
REQ-023 SHALL return, for a load accepted one cycle after a store to the same word, the store's data (write-then-read ordering).
REQ-024 SHALL leave read and write order for the same word on the same edge undefined, since only one request is accepted per cycle.
REQ-025 SHALL treat size 11 as an error: no write occurs, resp_err_o=1 and resp_rdata_o=0.
REQ-026 SHALL drive resp_rdata_o=0 and resp_err_o=0 whenever resp_valid_o=0.
REQ-027 SHALL not initialise the array contents; values read before the first write are undefined.

Reset
REQ-028 SHALL, while rst_i=0, asynchronously clear all pipeline-stage valid bits and drive resp_valid_o=0, resp_rdata_o=0, resp_err_o=0 and req_ready_o=0.
REQ-029 SHALL discard in-flight requests on a mid-operation reset with no response; stores already committed remain in the array.
REQ-030 SHALL leave array contents unchanged by reset.

Configuration
REQ-031 SHALL, when macro DMEM_MISALIGN_TRAP_EN is defined, treat a half access with addr[0]=1 or a word access with addr[1:0]!=0 as an error: no write occurs, resp_err_o=1 and resp_rdata_o=0.
REQ-032 SHALL, when DMEM_MISALIGN_TRAP_EN is undefined, force misaligned accesses aligned by clearing addr[0] for half accesses and addr[1:0] for word accesses, with resp_err_o=0.

Verification
REQ-033 SHALL cover, with LATENCY=1: word store 0xDEADBEEF at 0x10, then word load at 0x10 -> resp_valid_o one cycle later, rdata 0xDEADBEEF, err 0.
REQ-034 SHALL cover: byte store 0x80 at 0x13, then signed byte load 0x13 -> 0xFFFFFF80; unsigned byte load 0x13 -> 0x00000080; word load 0x10 -> 0x80ADBEEF.
REQ-035 SHALL cover, with LATENCY=3: back-to-back loads at 0x0, 0x4 and 0x8 over three consecutive cycles -> three consecutive resp_valid_o pulses starting three cycles after the first acceptance, in order.
REQ-036 SHALL cover, with DEPTH=16: word store at 0x40 -> read at 0x0 returns the same data (wrap-around).
REQ-037 SHALL cover: half store at 0x2 with DMEM_MISALIGN_TRAP_EN defined and addr 0x3 -> err 1, word at 0x0 unchanged; with the macro undefined -> writes lanes 2-3, err 0.
REQ-038 SHALL cover: rst_i driven low with two loads in flight -> no resp_valid_o; req_ready_o returns high on the second cycle after release; earlier stores are still readable.
